mem_port_arbiter: RTL

//  Shares one single-port 32-bit BRAM between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rd_track.sv | 67 ++++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        RQ_IF  = 2'd0,
        RQ_MEM = 2'd1,
        RQ_LD  = 2'd2
    } req_id_t;

    localparam int MAX_RD_LAT = 4;
    // Wide enough to hold MAX_RD_LAT-1.
    localparam int CNT_W      = 2;

endpackage

// File: rtl/mem_arb_rd_track.sv
// Read-latency tracker: counts down the BRAM read latency for the one
// outstanding read, remembers who owns it, and captures bram_dout into a
// one-cycle done pulse tagged with the owner.
module mem_arb_rd_track
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  req_id_t           start_id,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              last,
    output logic              done,
    output req_id_t           done_id,
    output logic [DATA_W-1:0] data
);

    logic              busy_p0;
    logic [CNT_W-1:0]  cnt_p0;
    req_id_t           owner_p0;
    logic              done_p1;
    req_id_t           done_id_p1;
    logic [DATA_W-1:0] data_p1;

    assign last    = busy_p0 && (cnt_p0 == '0);
    assign done    = done_p1;
    assign done_id = done_id_p1;
    assign data    = data_p1;

    // Latency down-counter and owner tag for the read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_p0  <= 1'b0;
            cnt_p0   <= '0;
            owner_p0 <= RQ_IF;
        end else if (start) begin
            busy_p0  <= 1'b1;
            cnt_p0   <= CNT_W'(RD_LAT - 1);
            owner_p0 <= start_id;
        end else if (busy_p0) begin
            if (cnt_p0 == '0) begin
                busy_p0 <= 1'b0;
            end else begin
                cnt_p0 <= cnt_p0 - CNT_W'(1);
            end
        end
    end

    // ---- stage p1: capture BRAM data and raise the done pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            done_p1    <= 1'b0;
            done_id_p1 <= RQ_IF;
            data_p1    <= '0;
        end else begin
            done_p1 <= last;
            if (last) begin
                done_id_p1 <= owner_p0;
                data_p1    <= bram_dout;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter between instruction fetch (IF) and load/store
// (MEM). Fixed priority MEM > IF; one read in flight at a time; stores
// complete in their grant cycle.
// Optional build macro MEM_ARB_LOADER_EN adds a store-only program-loader
// port (ld_*) with the highest priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_LOADER_EN
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
`endif
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              stall
);

    arb_state_t        state_p0;
    logic              idle;
    logic              ld_active;
    logic              ld_grant;
    logic [ADDR_W-1:0] ld_word;
    logic [DATA_W-1:0] ld_data;
    logic              rd_start;
    req_id_t           rd_id;
    logic [ADDR_W-1:0] addr_hold_p0;
    logic [DATA_W-1:0] din_hold_p0;
    logic [DATA_W-1:0] if_rdata_hold_p0;
    logic [DATA_W-1:0] mem_rdata_hold_p0;
    logic              trk_last;
    logic              trk_done;
    req_id_t           trk_done_id;
    logic [DATA_W-1:0] trk_data;
    logic              unused_addr_bits;

    // Grants are only handed out in IDLE and never while reset is asserted.
    assign idle = (state_p0 == ST_IDLE) && !rst;

`ifdef MEM_ARB_LOADER_EN
    assign ld_active = ld_req;
    assign ld_word   = ld_addr[ADDR_W+1:2];
    assign ld_data   = ld_wdata;
    assign ld_gnt    = ld_grant;
    assign unused_addr_bits = ^{if_addr, mem_addr, ld_addr};
`else
    assign ld_active = 1'b0;
    assign ld_word   = '0;
    assign ld_data   = '0;
    assign unused_addr_bits = ^{if_addr, mem_addr};
`endif

    assign ld_grant = idle && ld_active;
    assign mem_gnt  = idle && mem_req && !ld_active;
    assign if_gnt   = idle && if_req && !mem_req && !ld_active;
    assign bram_we  = ld_grant || (mem_gnt && mem_we);
    assign rd_start = if_gnt || (mem_gnt && !mem_we);
    assign rd_id    = if_gnt ? RQ_IF : RQ_MEM;

    // BRAM address/data mux: the granted requester, else the last granted value.
    always_comb begin
        bram_addr = addr_hold_p0;
        bram_din  = din_hold_p0;
        if (ld_grant) begin
            bram_addr = ld_word;
            bram_din  = ld_data;
        end else if (mem_gnt) begin
            bram_addr = mem_addr[ADDR_W+1:2];
            if (mem_we) begin
                bram_din = mem_wdata;
            end
        end else if (if_gnt) begin
            bram_addr = if_addr[ADDR_W+1:2];
        end
    end

    // Remember the last driven BRAM address/data so they hold between grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_p0 <= '0;
            din_hold_p0  <= '0;
        end else begin
            addr_hold_p0 <= bram_addr;
            din_hold_p0  <= bram_din;
        end
    end

    // Two-state FSM: IDLE grants, RD_WAIT blocks until the read data is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ST_IDLE;
        end else begin
            case (state_p0)
                ST_IDLE:    if (rd_start) state_p0 <= ST_RD_WAIT;
                ST_RD_WAIT: if (trk_last) state_p0 <= ST_IDLE;
                default:    state_p0 <= ST_IDLE;
            endcase
        end
    end

    mem_arb_rd_track #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_track (
        .clk       (clk),
        .rst       (rst),
        .start     (rd_start),
        .start_id  (rd_id),
        .bram_dout (bram_dout),
        .last      (trk_last),
        .done      (trk_done),
        .done_id   (trk_done_id),
        .data      (trk_data)
    );

    assign if_rvalid  = trk_done && (trk_done_id == RQ_IF);
    assign mem_rvalid = trk_done && (trk_done_id == RQ_MEM);
    assign if_rdata   = if_rvalid  ? trk_data : if_rdata_hold_p0;
    assign mem_rdata  = mem_rvalid ? trk_data : mem_rdata_hold_p0;

    // Per-requester read data holds between rvalid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_hold_p0  <= '0;
            mem_rdata_hold_p0 <= '0;
        end else begin
            if_rdata_hold_p0  <= if_rdata;
            mem_rdata_hold_p0 <= mem_rdata;
        end
    end

    assign stall = !rst && ((if_req && !if_gnt) || (mem_req && !mem_gnt) ||
                            (state_p0 == ST_RD_WAIT));

endmodule
